// File: rtl/axis_multi_bram_loader_if.sv
// AXI4-Stream bundle for the multi-target BRAM loader.
// The master drives data/valid and the slave returns ready.
interface axis_multi_bram_loader_if #(
  parameter int DATA_W = 32
);
  logic                  TREADY;
  logic [DATA_W-1:0]     TDATA;
  logic [DATA_W/8-1:0]   TSTRB;
  logic                  TLAST;
  logic                  TVALID;

  modport master (input TREADY, output TDATA, TSTRB, TLAST, TVALID);
  modport slave  (output TREADY, input TDATA, TSTRB, TLAST, TVALID);
endinterface

// File: rtl/axis_multi_bram_loader.sv
// Stream-ingest stage: writes AXI4-Stream beats into one of NUM_CH BRAM ports
// starting at a run-time base address, with a word limit, overflow drain and abort.
module axis_multi_bram_loader #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    S_AXIS_ACLK,
  input  logic                    S_AXIS_ARESET,
  input  logic                    start,
  input  logic                    abort,
  input  logic [SEL_W-1:0]        sel,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ADDR_W:0]         max_len,
  input  logic [NUM_CH-1:0]       clr_done,
  axis_multi_bram_loader_if.slave s_axis,
  output logic [ADDR_W-1:0]       bram_addr,
  output logic [DATA_W-1:0]       bram_din,
  output logic [NUM_CH-1:0]       bram_en,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic                    sel_err,
  output logic [ADDR_W:0]         words_written,
  output logic [NUM_CH-1:0]       ch_done
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FIN} state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    sel_q;
  logic [ADDR_W-1:0]   base_q;
  logic [CNT_W-1:0]    limit_q;
  logic                start_ok;
  logic                sel_bad;
  logic                beat;
  logic                wr_beat;
  logic                hit_limit;
  logic [NUM_CH-1:0]   sel_onehot;
  logic [NUM_CH-1:0]   fin_set;
  logic                unused_tstrb;

  // Every beat is treated as a full word, so byte strobes are deliberately dropped.
  assign unused_tstrb = ^s_axis.TSTRB;

  assign sel_bad       = 32'(sel) >= NUM_CH;
  assign s_axis.TREADY = (state_q == STREAM) || (state_q == DRAIN);
  assign beat          = s_axis.TVALID && s_axis.TREADY;
  assign busy          = (state_q != IDLE);
  assign hit_limit     = (words_written + CNT_W'(1)) == limit_q;
  assign sel_onehot    = NUM_CH'(1) << sel_q;
  assign fin_set       = ((state_q == FIN) && !sel_err) ? sel_onehot : '0;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    wr_beat  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = sel_bad ? FIN : STREAM;
        end
      end
      STREAM: begin
        wr_beat = beat;
        if (abort)                       state_d = IDLE;
        else if (beat && s_axis.TLAST)   state_d = FIN;
        else if (beat && hit_limit)      state_d = DRAIN;
      end
      DRAIN: begin
        if (abort)                       state_d = IDLE;
        else if (beat && s_axis.TLAST)   state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      base_q        <= '0;
      limit_q       <= '0;
      // NOTE: the write-data registers are reset too because they are visible
      // outputs that must read 0 while in reset, not merely internal storage.
      bram_addr     <= '0;
      bram_din      <= '0;
      bram_en       <= '0;
      done          <= 1'b0;
      overflow      <= 1'b0;
      sel_err       <= 1'b0;
      words_written <= '0;
      ch_done       <= '0;
    end else begin
      state_q <= state_d;
      bram_en <= wr_beat ? sel_onehot : '0;
      // done is registered so it lands in the cycle after the final write strobe.
      done    <= (state_q == FIN);
      ch_done <= (ch_done & ~clr_done) | fin_set;

      if (start_ok) begin
        sel_q         <= sel;
        base_q        <= base_addr;
        limit_q       <= (max_len == '0) ? (CNT_W'(1) << ADDR_W) : max_len;
        words_written <= '0;
        overflow      <= 1'b0;
        sel_err       <= sel_bad;
      end

      if (wr_beat) begin
        bram_addr     <= base_q + words_written[ADDR_W-1:0];
        bram_din      <= s_axis.TDATA;
        words_written <= words_written + CNT_W'(1);
      end

      if ((state_q == STREAM) && (state_d == DRAIN)) overflow <= 1'b1;
    end
  end

endmodule
